core_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes the 4-bit ALU control code that the ALU decoder emits for funct7[0]=1 R-type instructions and computes the result over several cycles. A start/busy/done handshake lets the hazard unit stall the pipeline while the operation runs.

---
 rtl/core_pkg.sv | 27 ++
 rtl/core_muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_core_muldiv_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
package core_pkg;

  // Default datapath width; one CALC cycle is spent per operand bit.
  localparam int MULDIV_XLEN  = 32;
  localparam int MULDIV_ITERS = MULDIV_XLEN;

  // Codes match the ALU decoder's funct7[0]=1 table (bit 3 of the ALU code is dropped).
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/core_muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide
// sharing one 2*XLEN accumulator, with sign fix-up in a final FIX cycle.
module core_muldiv_unit
  import core_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_muldiv_start,
  input  logic [3:0]      i_muldiv_op,
  input  logic [XLEN-1:0] i_muldiv_a,
  input  logic [XLEN-1:0] i_muldiv_b,
  input  logic [4:0]      i_muldiv_rd,
  input  logic            i_muldiv_flush,
  output logic            o_muldiv_busy,
  output logic            o_muldiv_done,
  output logic [XLEN-1:0] o_muldiv_result,
  output logic [4:0]      o_muldiv_rd
);

  // Iteration count tracks the width so other XLEN values keep one bit per cycle.
  localparam int ITERS = XLEN;
  localparam int CW    = $clog2(ITERS) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  muldiv_op_e        op_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opb_reg;
  logic              neg_res_reg, neg_rem_reg;
  logic [4:0]        rd_reg, rd_out_reg;
  logic [XLEN-1:0]   result_reg;

  // Bit 3 of the ALU code carries no meaning for the M-extension ops.
  logic unused_op_bit;
  assign unused_op_bit = i_muldiv_op[3];

  function automatic logic [2*XLEN-1:0] cneg(input logic n, input logic [2*XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Request decode: signedness, magnitudes and the immediate-completion cases.
  muldiv_op_e      op_in;
  logic            can_accept, accept;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign op_in      = muldiv_op_e'(i_muldiv_op[2:0]);
  assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign accept     = can_accept && i_muldiv_start && !i_muldiv_flush;
  assign a_signed   = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_signed   = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign a_neg      = a_signed && i_muldiv_a[XLEN-1];
  assign b_neg      = b_signed && i_muldiv_b[XLEN-1];
  assign a_mag      = a_neg ? (~i_muldiv_a + 1'b1) : i_muldiv_a;
  assign b_mag      = b_neg ? (~i_muldiv_b + 1'b1) : i_muldiv_b;
  assign div_zero   = op_in[2] && (i_muldiv_b == '0);
  assign div_ovf    = (op_in == OP_DIV || op_in == OP_REM) &&
                      (i_muldiv_a == INT_MIN) && (i_muldiv_b == '1);
  assign special    = div_zero || div_ovf;
  // op_in[1] separates the remainder ops (6,7) from the quotient ops (4,5).
  assign special_res = div_zero ? (op_in[1] ? i_muldiv_a : '1)
                                : (op_in[1] ? '0 : i_muldiv_a);

  // One iteration step of each algorithm on the shared accumulator.
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + ({1'b0, opb_reg} & {(XLEN+1){acc_reg[0]}});
  assign mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
  assign div_trial = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, opb_reg};
  assign div_next  = div_trial[XLEN] ? {acc_reg[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};

  // Sign correction of the finished magnitudes.
  logic [2*XLEN-1:0] prod_fix, quot_fix, rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign prod_fix = cneg(neg_res_reg, acc_reg);
  assign quot_fix = cneg(neg_res_reg, {{XLEN{1'b0}}, acc_reg[XLEN-1:0]});
  assign rem_fix  = cneg(neg_rem_reg, {{XLEN{1'b0}}, acc_reg[2*XLEN-1:XLEN]});

  // Select the architectural result for the latched op.
  always_comb begin
    fix_res = '0;
    case (op_reg)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quot_fix[XLEN-1:0];
      default:                      fix_res = rem_fix[XLEN-1:0];
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: flush overrides everything, start only from IDLE/DONE.
  always_comb begin
    state_next = state_reg;
    if (i_muldiv_flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: state_next = i_muldiv_start ? (special ? ST_DONE : ST_CALC) : ST_IDLE;
        ST_CALC:          state_next = (cnt_reg == '0) ? ST_FIX : ST_CALC;
        ST_FIX:           state_next = ST_DONE;
        default:          state_next = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_muldiv_busy = (state_reg == ST_CALC) || (state_reg == ST_FIX);
    o_muldiv_done = (state_reg == ST_DONE);
  end

  // Datapath: latch on accept, iterate in CALC, publish result in FIX.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_reg     <= '0;
      op_reg      <= OP_MUL;
      acc_reg     <= '0;
      opb_reg     <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      rd_reg      <= '0;
      rd_out_reg  <= '0;
      result_reg  <= '0;
    end else if (i_muldiv_flush) begin
      cnt_reg <= '0;
    end else if (accept) begin
      op_reg      <= op_in;
      rd_reg      <= i_muldiv_rd;
      acc_reg     <= {{XLEN{1'b0}}, a_mag};
      opb_reg     <= b_mag;
      neg_res_reg <= a_neg ^ b_neg;
      neg_rem_reg <= a_neg;
      cnt_reg     <= CW'(ITERS - 1);
      if (special) begin
        result_reg <= special_res;
        rd_out_reg <= i_muldiv_rd;
      end
    end else if (state_reg == ST_CALC) begin
      acc_reg <= op_reg[2] ? div_next : mul_next;
      if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
    end else if (state_reg == ST_FIX) begin
      result_reg <= fix_res;
      rd_out_reg <= rd_reg;
    end
  end

  assign o_muldiv_result = result_reg;
  assign o_muldiv_rd     = rd_out_reg;

endmodule

// File: tb/tb_core_muldiv_unit.sv
// Directed plus randomized checks of core_muldiv_unit against a plain-arithmetic model.
module tb_core_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;

  core_muldiv_unit #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_muldiv_start(start), .i_muldiv_op(op),
    .i_muldiv_a(a), .i_muldiv_b(b), .i_muldiv_rd(rd), .i_muldiv_flush(flush),
    .o_muldiv_busy(busy), .o_muldiv_done(done), .o_muldiv_result(result),
    .o_muldiv_rd(rd_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: RISC-V M semantics written with 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint    sx = longint'($signed(x));
    longint    sy = longint'($signed(y));
    longint    uy = longint'({32'b0, y});
    logic [63:0] p;
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin if (y == 0) return 32'hFFFFFFFF; p = sx / sy; return p[31:0]; end
      3'd5: begin if (y == 0) return 32'hFFFFFFFF; return x / y; end
      3'd6: begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
      default: begin if (y == 0) return x; return x % y; end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at the current negedge and follow it to its done pulse.
  task automatic do_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb, input logic [4:0] xrd);
    logic [31:0] exp;
    int          lat, exp_lat;
    bit          sp, hi;
    exp     = model(o, xa, xb);
    sp      = (o[2] && xb == 0) || ((o == 3'd4 || o == 3'd6) && xa == 32'h80000000 && xb == 32'hFFFFFFFF);
    exp_lat = sp ? 1 : 34;
    hi      = 1'($urandom_range(0, 1));
    chk("busy_at_start", {31'b0, busy}, 32'd0);
    start = 1'b1; op = {hi, o}; a = xa; b = xb; rd = xrd;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; rd = 5'($urandom);
    lat = 1;
    chk("busy_after_accept", {31'b0, busy}, sp ? 32'd0 : 32'd1);
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("result", result, exp);
    chk("rd", {27'b0, rd_o}, {27'b0, xrd});
    $display("op=%0d a=%h b=%h rd=%0d result=%h expect=%h lat=%0d", o, xa, xb, xrd, result, exp, lat);
  endtask

  initial begin
    logic [31:0] held;
    int          cnt_done, cnt_busy, lat;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", {27'b0, rd_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases; each follows directly in the DONE cycle of the previous one.
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
    chk("plan_mul", result, 32'hFFFFFFEB);
    do_op(3'd1, 32'h80000000, 32'h80000000, 5'd6);
    chk("plan_mulh", result, 32'h40000000);
    do_op(3'd3, 32'h80000000, 32'h80000000, 5'd7);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8);
    chk("plan_mulhsu", result, 32'hFFFFFFFF);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd9);
    chk("plan_div", result, 32'hFFFFFFFD);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd10);
    chk("plan_rem", result, 32'hFFFFFFFF);
    do_op(3'd5, 32'hFFFFFFFF, 32'd2, 5'd11);
    do_op(3'd4, 32'h00005678, 32'd0, 5'd12);
    do_op(3'd7, 32'h00001234, 32'd0, 5'd13);
    chk("plan_remu0", result, 32'h00001234);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15);
    do_op(3'd0, 32'h12345678, 32'h9ABCDEF0, 5'd16);

    // Done is a single pulse when nothing follows.
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("idle_not_busy", {31'b0, busy}, 32'd0);

    // Flush in cycle 10 of a DIV, with a simultaneous (dropped) start.
    held  = result;
    start = 1'b1; op = 4'd4; a = 32'd1000; b = 32'd7; rd = 5'd21;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd3; rd = 5'd22;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_held", result, held);
    cnt_done = 0; cnt_busy = 0;
    repeat (50) begin
      if (done) cnt_done++;
      if (busy) cnt_busy++;
      @(negedge clk);
    end
    chk("flush_no_done", cnt_done, 32'd0);
    chk("flush_start_dropped", cnt_busy, 32'd0);
    chk("flush_held_late", result, held);

    // Start while busy is ignored.
    start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd5; rd = 5'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lat = 1;
    repeat (5) begin @(negedge clk); lat++; end
    start = 1'b1; op = 4'd5; a = 32'd100; b = 32'd3; rd = 5'd20;
    @(negedge clk); lat++;
    start = 1'b0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    chk("busy_start_latency", lat, 32'd34);
    chk("busy_start_result", result, 32'd15);
    chk("busy_start_rd", {27'b0, rd_o}, 32'd3);
    $display("op=0 a=00000003 b=00000005 rd=3 result=%h expect=0000000f lat=%0d (start while busy)", result, lat);

    // Randomized ops, back to back, biased toward the special cases.
    repeat (40) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: rb = -32'($urandom_range(1, 20));
        default: ;
      endcase
      do_op(ro, ra, rb, 5'($urandom_range(1, 31)));
    end

    // Reset mid-CALC clears everything.
    start = 1'b1; op = 4'd3; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd", {27'b0, rd_o}, 32'd0);
    do_op(3'd1, 32'hFFFFFFFF, 32'd2, 5'd30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
